// File: rtl/fmap_collector_c1.sv
// fmap_collector_c1: feature-map collector between the pointwise conv layer and the next layer.
//   Captures one OUTPUT_CHANNEL*N-bit pixel vector per conv_din_vld into a PIX-word buffer
//   (pixel-major), then drains it as a serial N-bit valid/ready stream in channel-major order
//   (all pixels of channel 0, then channel 1, ...).
// Optional feature: define FMAP_RELU_EN to clamp negative elements to zero on the drain path.
// Ports:
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   ce              clock enable; low freezes all state
//   conv_din        pixel vector, channel i at [(i+1)*N-1:i*N]
//   conv_din_vld    vector valid (no backpressure upstream)
//   out_rdy         downstream ready
//   out_dout        serial output element
//   out_vld         out_dout valid
//   out_ch          channel index of out_dout
//   out_last        high with the final element of the map
//   busy            high while draining; upstream must not send
//   ovf_err         sticky: a vector arrived while draining
module fmap_collector_c1 #(
    parameter int unsigned N              = 16,
    parameter int unsigned INPUT_SIZE     = 6,
    parameter int unsigned OUTPUT_CHANNEL = 32,
    localparam int unsigned PIX           = INPUT_SIZE * INPUT_SIZE,
    localparam int unsigned CH_W          = (OUTPUT_CHANNEL > 1) ? $clog2(OUTPUT_CHANNEL) : 1,
    localparam int unsigned PIX_W         = (PIX > 1) ? $clog2(PIX) : 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        ce,
    input  logic [OUTPUT_CHANNEL*N-1:0] conv_din,
    input  logic                        conv_din_vld,
    input  logic                        out_rdy,
    output logic [N-1:0]                out_dout,
    output logic                        out_vld,
    output logic [CH_W-1:0]             out_ch,
    output logic                        out_last,
    output logic                        busy,
    output logic                        ovf_err
);

    typedef enum logic [0:0] {StFill, StDrain} state_e;

    state_e                      state_q, state_d;
    logic [PIX_W-1:0]            wr_ptr_q, wr_ptr_d;
    logic [CH_W-1:0]             ch_q, ch_d;
    logic [PIX_W-1:0]            pix_q, pix_d;
    logic [N-1:0]                out_dout_q, out_dout_d;
    logic                        out_vld_q, out_vld_d;
    logic [CH_W-1:0]             out_ch_q, out_ch_d;
    logic                        out_last_q, out_last_d;
    logic                        busy_q, busy_d;
    logic                        ovf_err_q, ovf_err_d;

    logic [OUTPUT_CHANNEL*N-1:0] mem_q [PIX];
    logic                        mem_we;
    logic [N-1:0]                elem;
    logic [N-1:0]                elem_out;
    logic                        xfer;

    always_comb begin
        elem = '0;
        for (int i = 0; i < int'(OUTPUT_CHANNEL); i++) begin
            if (ch_q == CH_W'(i)) begin
                elem = mem_q[pix_q][i*N +: N];
            end
        end
`ifdef FMAP_RELU_EN
        elem_out = elem[N-1] ? '0 : elem;
`else
        elem_out = elem;
`endif
    end

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        ch_d       = ch_q;
        pix_d      = pix_q;
        out_dout_d = out_dout_q;
        out_vld_d  = out_vld_q;
        out_ch_d   = out_ch_q;
        out_last_d = out_last_q;
        busy_d     = busy_q;
        ovf_err_d  = ovf_err_q;
        mem_we     = 1'b0;
        xfer       = out_vld_q & out_rdy;

        if (ce) begin
            unique case (state_q)
                StFill: begin
                    if (conv_din_vld) begin
                        mem_we = 1'b1;
                        if (wr_ptr_q == PIX_W'(PIX - 1)) begin
                            wr_ptr_d = '0;
                            state_d  = StDrain;
                            busy_d   = 1'b1;
                        end else begin
                            wr_ptr_d = wr_ptr_q + 1'b1;
                        end
                    end
                end
                StDrain: begin
                    if (conv_din_vld) begin
                        ovf_err_d = 1'b1;
                    end
                    if (xfer && out_last_q) begin
                        // Pointers already wrapped to (0,0) when the last element was loaded.
                        out_vld_d  = 1'b0;
                        out_last_d = 1'b0;
                        busy_d     = 1'b0;
                        state_d    = StFill;
                    end else if (!out_vld_q || xfer) begin
                        // Empty output register or a transfer this cycle: load next element.
                        out_dout_d = elem_out;
                        out_ch_d   = ch_q;
                        out_vld_d  = 1'b1;
                        out_last_d = (ch_q == CH_W'(OUTPUT_CHANNEL - 1)) &&
                                     (pix_q == PIX_W'(PIX - 1));
                        if (pix_q == PIX_W'(PIX - 1)) begin
                            pix_d = '0;
                            ch_d  = (ch_q == CH_W'(OUTPUT_CHANNEL - 1)) ? '0 : ch_q + 1'b1;
                        end else begin
                            pix_d = pix_q + 1'b1;
                        end
                    end
                end
                default: state_d = StFill;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StFill;
            wr_ptr_q   <= '0;
            ch_q       <= '0;
            pix_q      <= '0;
            out_dout_q <= '0;
            out_vld_q  <= 1'b0;
            out_ch_q   <= '0;
            out_last_q <= 1'b0;
            busy_q     <= 1'b0;
            ovf_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            ch_q       <= ch_d;
            pix_q      <= pix_d;
            out_dout_q <= out_dout_d;
            out_vld_q  <= out_vld_d;
            out_ch_q   <= out_ch_d;
            out_last_q <= out_last_d;
            busy_q     <= busy_d;
            ovf_err_q  <= ovf_err_d;
        end
    end

    // Buffer contents need no reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[wr_ptr_q] <= conv_din;
        end
    end

    assign out_dout = out_dout_q;
    assign out_vld  = out_vld_q;
    assign out_ch   = out_ch_q;
    assign out_last = out_last_q;
    assign busy     = busy_q;
    assign ovf_err  = ovf_err_q;

endmodule

// File: tb/tb_fmap_collector_c1.sv
// tb_fmap_collector_c1: directed self-checking bench for fmap_collector_c1
// (N=8, INPUT_SIZE=2, OUTPUT_CHANNEL=3, so 4 vectors per map and 12 drained beats).
module tb_fmap_collector_c1;

    localparam int unsigned N   = 8;
    localparam int unsigned IS  = 2;
    localparam int unsigned OC  = 3;
    localparam int unsigned PIX = IS * IS;
    localparam int unsigned NB  = PIX * OC;

    logic          clk;
    logic          rst_n;
    logic          ce;
    logic [OC*N-1:0] conv_din;
    logic          conv_din_vld;
    logic          out_rdy;
    logic [N-1:0]  out_dout;
    logic          out_vld;
    logic [1:0]    out_ch;
    logic          out_last;
    logic          busy;
    logic          ovf_err;

    int checks = 0;
    int errors = 0;

    logic [7:0] vec [PIX][OC];

    fmap_collector_c1 #(
        .N              (N),
        .INPUT_SIZE     (IS),
        .OUTPUT_CHANNEL (OC)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ce           (ce),
        .conv_din     (conv_din),
        .conv_din_vld (conv_din_vld),
        .out_rdy      (out_rdy),
        .out_dout     (out_dout),
        .out_vld      (out_vld),
        .out_ch       (out_ch),
        .out_last     (out_last),
        .busy         (busy),
        .ovf_err      (ovf_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] exp_val(input int k);
        logic [7:0] v;
        v = vec[k % PIX][k / PIX];
`ifdef FMAP_RELU_EN
        if (v[7]) v = 8'h00;
`endif
        return v;
    endfunction

    task automatic set_map(input int base);
        for (int p = 0; p < int'(PIX); p++)
            for (int c = 0; c < int'(OC); c++)
                vec[p][c] = 8'(base + 16 * p + c);
    endtask

    // Called at a negedge; returns at the negedge after the last write edge.
    task automatic fill(input bit pause);
        for (int p = 0; p < int'(PIX); p++) begin
            for (int c = 0; c < int'(OC); c++) conv_din[c*N +: N] = vec[p][c];
            conv_din_vld = 1'b1;
            if (pause && p == 2) begin
                // Hold a valid vector under ce=0: it must be written exactly once.
                ce = 1'b0;
                repeat (5) @(negedge clk);
                check_eq("fill_freeze_busy", 32'(busy), 32'd0);
                ce = 1'b1;
            end
            @(negedge clk);
            check_eq("fill_no_vld", 32'(out_vld), 32'd0);
        end
        conv_din_vld = 1'b0;
    endtask

    task automatic drain(input int rdy_mode, input bit inject, input int pause_at,
                         input int max_beats);
        int  k;
        int  cyc;
        bit  rdy;
        bit  paused;
        k = 0; cyc = 0; paused = 0;
        check_eq("drain_busy", 32'(busy), 32'd1);
        check_eq("drain_vld_latency", 32'(out_vld), 32'd0);
        if (inject) begin
            conv_din     = '1;
            conv_din_vld = 1'b1;
        end
        out_rdy = 1'b1;
        @(negedge clk);
        conv_din_vld = 1'b0;
        check_eq("first_vld", 32'(out_vld), 32'd1);
        while (k < max_beats && cyc < 200) begin
            if (pause_at == k && !paused) begin
                paused  = 1;
                ce      = 1'b0;
                out_rdy = 1'b1;
                repeat (5) begin
                    @(negedge clk);
                    check_eq("freeze_dout", 32'(out_dout), 32'(exp_val(k)));
                    check_eq("freeze_vld", 32'(out_vld), 32'd1);
                end
                ce = 1'b1;
            end
            rdy     = (rdy_mode == 0) ? 1'b1 : (cyc % 2 == 0);
            out_rdy = rdy;
            check_eq("beat_vld", 32'(out_vld), 32'd1);
            if (out_vld) begin
                check_eq("beat_dout", 32'(out_dout), 32'(exp_val(k)));
                check_eq("beat_ch", 32'(out_ch), 32'(k / PIX));
                check_eq("beat_last", 32'(out_last), 32'(k == int'(NB) - 1));
                if (rdy) k++;
            end
            @(negedge clk);
            cyc++;
        end
        if (cyc >= 200) check_eq("drain_timeout", 32'(k), 32'(max_beats));
        if (k == int'(NB)) begin
            check_eq("end_vld", 32'(out_vld), 32'd0);
            check_eq("end_busy", 32'(busy), 32'd0);
            check_eq("end_last", 32'(out_last), 32'd0);
        end
    endtask

    initial begin
        rst_n        = 1'b0;
        ce           = 1'b1;
        conv_din     = '0;
        conv_din_vld = 1'b0;
        out_rdy      = 1'b0;
        #3;
        check_eq("rst_dout", 32'(out_dout), 32'd0);
        check_eq("rst_vld", 32'(out_vld), 32'd0);
        check_eq("rst_ch", 32'(out_ch), 32'd0);
        check_eq("rst_last", 32'(out_last), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_ovf", 32'(ovf_err), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: full-throughput drain
        set_map(0);
        fill(1'b0);
        drain(0, 1'b0, -1, NB);
        check_eq("s1_ovf", 32'(ovf_err), 32'd0);

        // 2: ready toggling
        fill(1'b0);
        drain(1, 1'b0, -1, NB);
        check_eq("s2_ovf", 32'(ovf_err), 32'd0);

        // 3: overflow in first drain cycle, then back-to-back next map
        fill(1'b0);
        drain(0, 1'b1, -1, NB);
        check_eq("s3_ovf", 32'(ovf_err), 32'd1);
        set_map(4);
        fill(1'b0);
        drain(0, 1'b0, -1, NB);
        check_eq("s3_ovf_sticky", 32'(ovf_err), 32'd1);

        // 4: clock-enable freeze mid-fill and mid-drain
        set_map(0);
        fill(1'b1);
        drain(0, 1'b0, 5, NB);

        // 5: asynchronous reset mid-drain
        fill(1'b0);
        drain(0, 1'b0, -1, 5);
        #2 rst_n = 1'b0;
        #1;
        check_eq("arst_dout", 32'(out_dout), 32'd0);
        check_eq("arst_vld", 32'(out_vld), 32'd0);
        check_eq("arst_ch", 32'(out_ch), 32'd0);
        check_eq("arst_last", 32'(out_last), 32'd0);
        check_eq("arst_busy", 32'(busy), 32'd0);
        check_eq("arst_ovf", 32'(ovf_err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        set_map(8);
        fill(1'b0);
        drain(0, 1'b0, -1, NB);

        // 6: negative element on channel 0
        set_map(0);
        vec[0][0] = 8'hFB;
        vec[1][0] = 8'h07;
        fill(1'b0);
`ifdef FMAP_RELU_EN
        check_eq("s6_model_neg", 32'(exp_val(0)), 32'h00);
`else
        check_eq("s6_model_neg", 32'(exp_val(0)), 32'hFB);
`endif
        drain(0, 1'b0, -1, NB);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
